// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_lock;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  mem_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output mem_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (fetch = port 0, load/store = port 1) onto one single-port RAM, with port 1 lock.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed priority to port 1.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

   lock_state_e       state_q, state_d;
   logic              rv0_q, rv1_q;
   logic              gnt0, gnt1;
   logic              we_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;  // 1 = port 1 wins the next contention

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= 1'b1;
      else      ptr_q <= ptr_d;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt0)      ptr_d = 1'b1;
      else if (gnt1) ptr_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= UNLOCKED;
      else      state_q <= state_d;
   end

   // Every port 1 grant re-samples the lock; otherwise the state holds.
   always_comb begin
      state_d = state_q;
      if (gnt1) state_d = bus.m1_lock ? LOCKED : UNLOCKED;
   end

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst) begin
         if (state_q == LOCKED) begin
            gnt1 = bus.m1_req;
         end else if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt1 = ptr_q;
            gnt0 = ~ptr_q;
`else
            gnt1 = 1'b1;
`endif
         end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
         end
      end
   end

   always_comb begin
      we_mux    = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      if (gnt1) begin
         we_mux    = bus.m1_we;
         addr_mux  = bus.m1_addr;
         wdata_mux = bus.m1_wdata;
      end else if (gnt0) begin
         we_mux    = bus.m0_we;
         addr_mux  = bus.m0_addr;
         wdata_mux = bus.m0_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rv0_q <= 1'b0;
         rv1_q <= 1'b0;
      end else begin
         rv0_q <= gnt0 & ~bus.m0_we;
         rv1_q <= gnt1 & ~bus.m1_we;
      end
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.mem_en    = gnt0 | gnt1;
   assign bus.mem_we    = we_mux;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.m0_rvalid = rv0_q;
   assign bus.m1_rvalid = rv1_q;
   assign bus.m0_rdata  = bus.mem_rdata;
   assign bus.m1_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grants, lock and memory.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ival(input int i);
      return 32'hDEAD_0000 + i * 32'h0101_0011;
   endfunction

   // Bench-side RAM; initial contents are loaded while reset is held across clock edges.
   logic [31:0] ram [16];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= ival(i);
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr[5:2]];
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // Requester stimulus state
   logic        r_req   [2];
   logic        r_we    [2];
   logic [31:0] r_addr  [2];
   logic [31:0] r_wdata [2];
   logic        r_lock;

   // Reference model state
   bit          m_locked;
   int          m_last;      // port granted most recently
   bit          e_rv [2];
   logic [31:0] e_rdata;
   logic [31:0] mdl [16];
   bit          e_g [2];
   bit          last_rd0;

   task automatic drive(input int preq, input int plock);
      for (int p = 0; p < 2; p++) begin
         if (e_g[p]) r_req[p] = 1'b0;
         if (!r_req[p] && ($urandom_range(99) < preq)) begin
            r_req[p]   = 1'b1;
            r_we[p]    = 1'($urandom_range(1));
            r_addr[p]  = $urandom & 32'hFFFF_FF3C;
            r_wdata[p] = $urandom;
            if (p == 1) r_lock = ($urandom_range(99) < plock);
         end
      end
      if (!r_req[1]) r_lock = 1'($urandom_range(1));
      bus.m0_req   = r_req[0];
      bus.m0_we    = r_we[0];
      bus.m0_addr  = r_addr[0];
      bus.m0_wdata = r_wdata[0];
      bus.m1_req   = r_req[1];
      bus.m1_we    = r_we[1];
      bus.m1_addr  = r_addr[1];
      bus.m1_wdata = r_wdata[1];
      bus.m1_lock  = r_lock;
   endtask

   task automatic check_cycle();
      bit          g0, g1;
      int          p;
      logic        x_we;
      logic [31:0] x_addr, x_wdata;
      if (m_locked) begin
         g0 = 1'b0;
         g1 = r_req[1];
      end else if (r_req[0] && r_req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
         g1 = (m_last == 0);
`else
         g1 = 1'b1;
`endif
         g0 = !g1;
      end else begin
         g0 = r_req[0];
         g1 = r_req[1];
      end
      p       = g1 ? 1 : 0;
      x_we    = (g0 || g1) ? r_we[p]    : 1'b0;
      x_addr  = (g0 || g1) ? r_addr[p]  : 32'h0;
      x_wdata = (g0 || g1) ? r_wdata[p] : 32'h0;

      chk("m0_gnt", bus.m0_gnt, g0);
      chk("m1_gnt", bus.m1_gnt, g1);
      chk("mem_en", bus.mem_en, g0 | g1);
      chk("mem_we", bus.mem_we, x_we);
      chk("mem_addr", bus.mem_addr, x_addr);
      chk("mem_wdata", bus.mem_wdata, x_wdata);
      chk("m0_rvalid", bus.m0_rvalid, e_rv[0]);
      chk("m1_rvalid", bus.m1_rvalid, e_rv[1]);
      if (e_rv[0]) chk("m0_rdata", bus.m0_rdata, e_rdata);
      if (e_rv[1]) chk("m1_rdata", bus.m1_rdata, e_rdata);

      e_rv[0]  = 1'b0;
      e_rv[1]  = 1'b0;
      last_rd0 = g0 && !r_we[0];
      if (g0 || g1) begin
         m_last = p;
         if (r_we[p]) mdl[r_addr[p][5:2]] = r_wdata[p];
         else begin
            e_rv[p] = 1'b1;
            e_rdata = mdl[r_addr[p][5:2]];
         end
         if (g1) m_locked = r_lock;
      end
      e_g[0] = g0;
      e_g[1] = g1;
   endtask

   task automatic run(input int n, input int preq, input int plock, input bit arm);
      bit armed = arm;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         drive(preq, plock);
         if (armed && last_rd0) begin
            armed = 1'b0;
            rst   = 1'b0;
            #1;
            chk("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
            chk("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
            chk("rst_gnt", {31'b0, bus.m0_gnt | bus.m1_gnt}, 32'h0);
            chk("rst_mem_en", bus.mem_en, 1'b0);
            m_locked = 1'b0;
            m_last   = 0;
            e_rv[0]  = 1'b0;
            e_rv[1]  = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #1;
         end else begin
            @(negedge clk);
         end
         check_cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mdl[i] = ival(i);
      for (int p = 0; p < 2; p++) begin
         r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wdata[p] = '0;
         e_g[p] = 1'b0; e_rv[p] = 1'b0;
      end
      r_lock   = 1'b0;
      m_locked = 1'b0;
      m_last   = 0;
      last_rd0 = 1'b0;
      e_rdata  = '0;
      drive(0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_m0_gnt", bus.m0_gnt, 1'b0);
      chk("reset_m1_gnt", bus.m1_gnt, 1'b0);
      chk("reset_mem_en", bus.mem_en, 1'b0);
      chk("reset_m0_rvalid", bus.m0_rvalid, 1'b0);
      chk("reset_m1_rvalid", bus.m1_rvalid, 1'b0);
      rst = 1'b1;

      run(10, 0, 0, 1'b0);      // idle
      run(300, 50, 20, 1'b0);   // mixed traffic with locks
      run(60, 100, 10, 1'b0);   // sustained contention
      run(100, 60, 10, 1'b1);   // includes one reset right after an m0 read grant
      run(200, 40, 30, 1'b0);
      run(10, 0, 0, 1'b0);      // drain to idle

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
